// File: rtl/mem_stage_pkg.sv
// Shared decode constants, access sizes and FSM states for the load/store stage.
package mem_stage_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_STORE = 5'b01000;

  // funct3[1:0] access size
  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  // True when the byte offset is not a multiple of the access size.
  function automatic logic misaligned(input logic [1:0] sz, input logic [2:0] off);
    case (sz)
      2'd0:    return 1'b0;
      2'd1:    return off[0];
      2'd2:    return |off[1:0];
      default: return |off;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_ls_align.sv
// Byte-lane alignment: store mask/data shifting and load extraction with sign/zero extension.
module ls_align
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      off,
  input  size_e           size,
  input  logic            uns,
  input  logic [XLEN-1:0] sdata,
  input  logic [XLEN-1:0] rdata,
  output logic [7:0]      wmask,
  output logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] ldata
);

  logic [XLEN-1:0] shifted;

  // Shift store data up to its lane and build the byte enables for the access size.
  always_comb begin
    wdata = sdata << {off, 3'b000};
    wmask = 8'h00;
    unique case (size)
      SZ_B:    wmask = 8'h01 << off;
      SZ_H:    wmask = 8'h03 << off;
      SZ_W:    wmask = 8'h0F << off;
      default: wmask = 8'hFF;
    endcase
  end

  // Bring the addressed lane down to bit 0, then sign or zero extend to XLEN.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    ldata   = shifted;
    unique case (size)
      SZ_B: ldata = uns ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                        : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      SZ_H: ldata = uns ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                        : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      SZ_W: ldata = uns ? {{(XLEN-32){1'b0}}, shifted[31:0]}
                        : {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      default: ldata = shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Load/store pipeline stage: one instruction in flight, req/gnt/rvalid data bus, valid/ready to writeback.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter int INST_LEN = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [XLEN-1:0]     pc_i,
  input  logic [INST_LEN-1:0] instr_i,
  input  logic [XLEN-1:0]     alures_i,
  input  logic [XLEN-1:0]     rs2_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [XLEN-1:0]     pc_o,
  output logic [INST_LEN-1:0] instr_o,
  output logic [XLEN-1:0]     alures_o,
  output logic [XLEN-1:0]     lsres_o,
  output logic                misalign_o,
  output logic                dmem_req_o,
  output logic                dmem_we_o,
  output logic [XLEN-1:0]     dmem_addr_o,
  output logic [XLEN-1:0]     dmem_wdata_o,
  output logic [7:0]          dmem_wmask_o,
  input  logic                dmem_gnt_i,
  input  logic                dmem_rvalid_i,
  input  logic [XLEN-1:0]     dmem_rdata_i
);

  state_e              state_q, state_d;
  logic [XLEN-1:0]     pc_q, alures_q, rs2_q, lsres_q;
  logic [INST_LEN-1:0] instr_q;
  logic                killed_q;

  logic                ld_in, st_in, mis_in, go_req, accept, kill_now, st_q;
  size_e               sz_q;
  logic [7:0]          al_wmask;
  logic [XLEN-1:0]     al_wdata, al_ldata;

  // Incoming-instruction decode
  assign ld_in  = (instr_i[6:2] == OPC_LOAD);
  assign st_in  = (instr_i[6:2] == OPC_STORE);
  assign mis_in = (ld_in | st_in) & misaligned(instr_i[13:12], alures_i[2:0]);
  assign go_req = (ld_in | st_in) & ~mis_in;

  // Flush wins over accept; a killed access keeps the stage busy until it drains.
  assign in_ready_o = (state_q == IDLE) | ((state_q == DONE) & out_ready_i);
  assign accept     = in_valid_i & in_ready_o & ~flush_i;
  assign misalign_o = accept & mis_in;
  assign kill_now   = killed_q | flush_i;

  assign st_q = (instr_q[6:2] == OPC_STORE);
  assign sz_q = size_e'(instr_q[13:12]);

  // Bus fields are only driven while a request is up.
  assign dmem_req_o   = (state_q == REQ);
  assign dmem_we_o    = dmem_req_o & st_q;
  assign dmem_addr_o  = dmem_req_o ? {alures_q[XLEN-1:3], 3'b000} : '0;
  assign dmem_wdata_o = dmem_we_o ? al_wdata : '0;
  assign dmem_wmask_o = dmem_we_o ? al_wmask : '0;

  assign out_valid_o = (state_q == DONE) & ~killed_q;
  assign pc_o        = pc_q;
  assign instr_o     = instr_q;
  assign alures_o    = alures_q;
  assign lsres_o     = lsres_q;

  ls_align #(.XLEN(XLEN)) u_align (
    .off   (alures_q[2:0]),
    .size  (sz_q),
    .uns   (instr_q[14]),
    .sdata (rs2_q),
    .rdata (dmem_rdata_i),
    .wmask (al_wmask),
    .wdata (al_wdata),
    .ldata (al_ldata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state: a granted request is never abandoned; killed accesses drain back to IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = go_req ? REQ : DONE;
      REQ:  if (dmem_gnt_i) state_d = !st_q ? WAIT : (kill_now ? IDLE : DONE);
      WAIT: if (dmem_rvalid_i) state_d = kill_now ? IDLE : DONE;
      DONE: begin
        if (flush_i)          state_d = IDLE;
        else if (accept)      state_d = go_req ? REQ : DONE;
        else if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Capture the instruction on accept, the load result on rvalid, and the kill flag on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      instr_q  <= '0;
      alures_q <= '0;
      rs2_q    <= '0;
      lsres_q  <= '0;
      killed_q <= 1'b0;
    end else begin
      if (accept) begin
        pc_q     <= pc_i;
        instr_q  <= instr_i;
        alures_q <= alures_i;
        rs2_q    <= rs2_data_i;
        lsres_q  <= '0;
        killed_q <= 1'b0;
      end else if (flush_i && (state_q == REQ || state_q == WAIT)) begin
        killed_q <= 1'b1;
      end
      if (state_q == WAIT && dmem_rvalid_i && !kill_now) lsres_q <= al_ldata;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed and randomized bench for mem_stage with a byte-level memory reference model.
module tb_mem_stage;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        flush_i = 0, in_valid_i = 0, in_ready_o;
  logic [63:0] pc_i = 0, alures_i = 0, rs2_data_i = 0;
  logic [31:0] instr_i = 0;
  logic        out_valid_o, out_ready_i = 0;
  logic [63:0] pc_o, alures_o, lsres_o;
  logic [31:0] instr_o;
  logic        misalign_o, dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic [7:0]  dmem_wmask_o;
  logic        dmem_gnt_i = 0, dmem_rvalid_i = 0;
  logic [63:0] dmem_rdata_i = 0;

  mem_stage #(.XLEN(64), .INST_LEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .pc_i(pc_i), .instr_i(instr_i), .alures_i(alures_i), .rs2_data_i(rs2_data_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .pc_o(pc_o), .instr_o(instr_o), .alures_o(alures_o), .lsres_o(lsres_o),
    .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wmask_o(dmem_wmask_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  always #5 clk = ~clk;

  localparam logic [4:0] OP_LOAD = 5'b00000, OP_STORE = 5'b01000, OP_ADD = 5'b01100;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk(input logic [4:0] opc, input logic [2:0] f3);
    return {17'd0, f3, 5'd0, opc, 2'b11};
  endfunction

  task automatic chk_reset(input string t);
    chk({t, "_in_ready"}, in_ready_o, 1);
    chk({t, "_out_valid"}, out_valid_o, 0);
    chk({t, "_req"}, dmem_req_o, 0);
    chk({t, "_we"}, dmem_we_o, 0);
    chk({t, "_misalign"}, misalign_o, 0);
    chk({t, "_pc"}, pc_o, 0);
    chk({t, "_instr"}, instr_o, 0);
    chk({t, "_alures"}, alures_o, 0);
    chk({t, "_lsres"}, lsres_o, 0);
    chk({t, "_addr"}, dmem_addr_o, 0);
    chk({t, "_wdata"}, dmem_wdata_o, 0);
    chk({t, "_wmask"}, dmem_wmask_o, 0);
  endtask

  // Minimum-latency load: gnt in the first REQ cycle, rvalid the cycle after.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [63:0] a,
                         input logic [63:0] rd, input logic [63:0] exp);
    in_valid_i = 1; instr_i = mk(OP_LOAD, f3); alures_i = a; pc_i = 64'h400;
    step();
    in_valid_i = 0; dmem_gnt_i = 1;
    smp();
    chk({tag, "_req"}, dmem_req_o, 1);
    chk({tag, "_addr"}, dmem_addr_o, a & ~64'h7);
    step();
    dmem_gnt_i = 0; dmem_rvalid_i = 1; dmem_rdata_i = rd;
    smp();
    chk({tag, "_wait_nov"}, out_valid_o, 0);
    step();
    dmem_rvalid_i = 0;
    smp();
    chk({tag, "_valid"}, out_valid_o, 1);
    chk({tag, "_lsres"}, lsres_o, exp);
    step();
  endtask

  // ---------------- reference memory model (byte granular) ----------------
  logic [7:0] mb [logic [63:0]];

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] a, input logic [2:0] f3);
    int n;
    logic [63:0] v;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v | (64'(mb[a + 64'(i)]) << (8 * i));
    if (!f3[2] && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
    return v;
  endfunction

  task automatic model_store(input logic [63:0] a, input logic [2:0] f3, input logic [63:0] d);
    for (int i = 0; i < size_of(f3); i++) mb[a + 64'(i)] = d[8*i +: 8];
  endtask

  typedef struct {
    logic [63:0] pc, alures, lsres;
    logic [31:0] instr;
  } exp_t;
  exp_t expq[$];
  exp_t mon_e;

  // ---------------- bus responder (word memory, random gnt/rvalid delays) ----------------
  logic [63:0] wm [logic [63:0]];
  logic        auto_bus = 0, rnd_mode = 0, mon_en = 0;
  logic        rd_pend = 0;
  int          rd_cnt = 0;
  logic [63:0] rd_addr = 0, bm;

  initial forever begin
    @(posedge clk); #1;
    if (auto_bus) begin
      dmem_rvalid_i = 0;
      if (rd_pend) begin
        if (rd_cnt == 0) begin
          dmem_rvalid_i = 1; dmem_rdata_i = wm[rd_addr]; rd_pend = 0;
        end else rd_cnt--;
      end
      dmem_gnt_i = 0;
      if (dmem_req_o && $urandom_range(0, 2) == 0) begin
        dmem_gnt_i = 1;
        if (dmem_we_o) begin
          for (int b = 0; b < 8; b++) bm[8*b +: 8] = {8{dmem_wmask_o[b]}};
          wm[dmem_addr_o >> 3] = (wm[dmem_addr_o >> 3] & ~bm) | (dmem_wdata_o & bm);
        end else begin
          rd_pend = 1; rd_cnt = $urandom_range(0, 2); rd_addr = dmem_addr_o >> 3;
        end
      end
    end
  end

  // Random writeback backpressure
  initial forever begin
    @(posedge clk); #1;
    if (rnd_mode) out_ready_i = ($urandom_range(0, 3) != 0);
  end

  // Output monitor for the randomized phase
  always @(negedge clk) begin
    if (mon_en && out_valid_o && out_ready_i) begin
      if (expq.size() == 0) chk("rnd_unexpected_out", 1, 0);
      else begin
        mon_e = expq.pop_front();
        chk("rnd_pc", pc_o, mon_e.pc);
        chk("rnd_instr", 64'(instr_o), 64'(mon_e.instr));
        chk("rnd_alures", alures_o, mon_e.alures);
        chk("rnd_lsres", lsres_o, mon_e.lsres);
      end
    end
  end

  initial begin
    logic [31:0] ins;
    logic [63:0] a, d, w;
    logic [2:0]  f3;
    logic [4:0]  opc;
    logic        acc, mis;
    int          kind;
    exp_t        e;

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    smp();
    chk_reset("reset");
    step();
    rst_n = 1;

    // ---- three back-to-back ADDs ----
    out_ready_i = 1;
    for (int k = 0; k < 3; k++) begin
      in_valid_i = 1; instr_i = mk(OP_ADD, 3'd0); alures_i = 64'h1234; pc_i = 64'h100 + 64'(4 * k);
      step();
      smp();
      chk("add_valid", out_valid_o, 1);
      chk("add_pc", pc_o, 64'h100 + 64'(4 * k));
      chk("add_alures", alures_o, 64'h1234);
      chk("add_lsres", lsres_o, 0);
    end
    in_valid_i = 0;
    step();
    smp();
    chk("add_drain_valid", out_valid_o, 0);

    // ---- SH at 0x8000_0006, gnt in the third REQ cycle ----
    in_valid_i = 1; instr_i = mk(OP_STORE, 3'b001); alures_i = 64'h8000_0006; rs2_data_i = 64'hABCD;
    step();
    in_valid_i = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) dmem_gnt_i = 1;
      smp();
      chk("sh_req", dmem_req_o, 1);
      chk("sh_we", dmem_we_o, 1);
      chk("sh_addr", dmem_addr_o, 64'h8000_0000);
      chk("sh_wmask", dmem_wmask_o, 8'hC0);
      chk("sh_wdata", dmem_wdata_o, 64'hABCD_0000_0000_0000);
      step();
    end
    dmem_gnt_i = 0;
    smp();
    chk("sh_req_off", dmem_req_o, 0);
    chk("sh_valid", out_valid_o, 1);
    chk("sh_lsres", lsres_o, 0);
    step();

    // ---- load extraction / extension ----
    do_load("lb", 3'b000, 64'h1003, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    do_load("lbu", 3'b100, 64'h1003, 64'h0000_0000_8000_0000, 64'h80);
    do_load("lwu", 3'b110, 64'h1004, 64'h8000_0001_0000_0000, 64'h0000_0000_8000_0001);
    do_load("lh", 3'b001, 64'h1006, 64'hF234_0000_0000_0000, 64'hFFFF_FFFF_FFFF_F234);
    do_load("ld", 3'b011, 64'h1008, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

    // ---- misaligned LW ----
    in_valid_i = 1; instr_i = mk(OP_LOAD, 3'b010); alures_i = 64'h1002;
    smp();
    chk("mis_pulse", misalign_o, 1);
    step();
    in_valid_i = 0;
    smp();
    chk("mis_pulse_end", misalign_o, 0);
    chk("mis_no_req", dmem_req_o, 0);
    chk("mis_valid", out_valid_o, 1);
    chk("mis_lsres", lsres_o, 0);
    step();

    // ---- flush while a load waits for rvalid ----
    in_valid_i = 1; instr_i = mk(OP_LOAD, 3'b011); alures_i = 64'h1008;
    step();
    in_valid_i = 0; dmem_gnt_i = 1;
    step();
    dmem_gnt_i = 0; flush_i = 1;
    smp();
    chk("flw_ready_busy", in_ready_o, 0);
    step();
    flush_i = 0;
    smp();
    chk("flw_nov1", out_valid_o, 0);
    step();
    dmem_rvalid_i = 1; dmem_rdata_i = 64'hDEAD_BEEF;
    smp();
    chk("flw_ready_drain", in_ready_o, 0);
    step();
    dmem_rvalid_i = 0;
    smp();
    chk("flw_ready_after", in_ready_o, 1);
    chk("flw_nov2", out_valid_o, 0);
    step();

    // ---- flush in DONE ----
    out_ready_i = 0;
    in_valid_i = 1; instr_i = mk(OP_ADD, 3'd0); alures_i = 64'h55; pc_i = 64'h180;
    step();
    in_valid_i = 0; flush_i = 1;
    step();
    flush_i = 0;
    smp();
    chk("fld_nov", out_valid_o, 0);
    chk("fld_ready", in_ready_o, 1);

    // ---- stall in DONE: outputs held, next instr waits ----
    in_valid_i = 1; instr_i = mk(OP_ADD, 3'd0); alures_i = 64'h77; pc_i = 64'h200;
    step();
    pc_i = 64'h300; alures_i = 64'h99;
    for (int k = 0; k < 4; k++) begin
      smp();
      chk("stall_valid", out_valid_o, 1);
      chk("stall_pc", pc_o, 64'h200);
      chk("stall_alures", alures_o, 64'h77);
      chk("stall_ready", in_ready_o, 0);
      step();
    end
    out_ready_i = 1;
    smp();
    chk("stall_release_ready", in_ready_o, 1);
    step();
    in_valid_i = 0;
    smp();
    chk("b2b_pc", pc_o, 64'h300);
    chk("b2b_valid", out_valid_o, 1);
    step();

    // ---- reset in the middle of a store request ----
    in_valid_i = 1; instr_i = mk(OP_STORE, 3'b011); alures_i = 64'h1010; rs2_data_i = 64'h1122_3344_5566_7788;
    step();
    in_valid_i = 0;
    smp();
    chk("rstreq_req", dmem_req_o, 1);
    chk("rstreq_wmask", dmem_wmask_o, 8'hFF);
    #2; rst_n = 0; #1;
    chk_reset("midreset");
    step();
    rst_n = 1;
    step();

    // ---- randomized traffic vs. reference model ----
    for (int wi = 0; wi < 8; wi++) begin
      w = {$urandom, $urandom};
      wm[(64'h1000 >> 3) + 64'(wi)] = w;
      for (int b = 0; b < 8; b++) mb[64'h1000 + 64'(8 * wi + b)] = w[8*b +: 8];
    end
    auto_bus = 1; rnd_mode = 1; mon_en = 1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      a = 64'h1000 + 64'($urandom_range(0, 63));
      d = {$urandom, $urandom};
      if (kind == 0) begin
        opc = OP_ADD; f3 = 3'($urandom_range(0, 7)); a = {$urandom, $urandom};
      end else if (kind == 1) begin
        opc = OP_LOAD; f3 = 3'($urandom_range(0, 6));
      end else begin
        opc = OP_STORE; f3 = 3'($urandom_range(0, 3));
      end
      ins = mk(opc, f3) | ({$urandom} & 32'hFFF0_0F80);
      pc_i = {$urandom, $urandom}; instr_i = ins; alures_i = a; rs2_data_i = d;
      in_valid_i = 1;
      acc = 0;
      for (int t = 0; t < 100 && !acc; t++) begin
        smp();
        if (in_ready_o) begin
          acc = 1;
          mis = (kind != 0) && ((a % 64'(size_of(f3))) != 0);
          e.pc = pc_i; e.instr = ins; e.alures = a; e.lsres = 0;
          if (kind == 1 && !mis) e.lsres = model_load(a, f3);
          if (kind == 2 && !mis) model_store(a, f3, d);
          expq.push_back(e);
          chk("rnd_misalign", misalign_o, mis);
        end
        step();
      end
      if (!acc) chk("rnd_accept_timeout", 0, 1);
      in_valid_i = 0;
      if ($urandom_range(0, 3) == 0) step();
    end
    for (int t = 0; t < 200 && expq.size() != 0; t++) step();
    chk("rnd_drain", 64'(expq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
